data_mem_access_unit: RTL and testbench

- Initiator side of the word-addressed data memory port: converts processor load/store requests (byte, halfword, word; signed/unsigned) into MemRead/MemWrite word transactions.
- Performs sub-word extraction with sign/zero extension for loads and read-modify-write for SB/SH.
- Flags misaligned, out-of-range and illegal-size requests as faults without touching memory.
- Sits between the MIPS execute/mem stage and the data memory, which writes on negedge clk and reads combinationally.

---
 rtl/data_mem_access_unit.sv | 79 +++++++
 tb/tb_data_mem_access_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: load/store initiator for a word-addressed data memory with sub-word access and fault checks
module data_mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  done,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE, FAULT} state_t;
  state_t state;
  logic [2:0] sz;
  logic [ADDR_WIDTH+1:0] addr;
  logic [31:0] wbuf, msk, lane, ld, merged;
  logic [4:0] sh;
  logic bad;
  // size[0] selects halfword lanes, size[1] a full word, size[2] zero-extension
  assign sh = sz[0] ? {addr[1], 4'b0} : {addr[1:0], 3'b0};
  assign msk = (sz[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
  assign lane = mem_rdata >> sh;
  assign ld = sz[1] ? mem_rdata
            : sz[0] ? {{16{~sz[2] & lane[15]}}, lane[15:0]}
            : {{24{~sz[2] & lane[7]}}, lane[7:0]};
  assign merged = (mem_rdata & ~msk) | ((wbuf << sh) & msk);
  assign bad = !(req_size inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101})
             | (|req_addr[31:ADDR_WIDTH+2])
             | (req_size[1:0] == 2'b01 & req_addr[0])
             | (req_size == 3'b011 & |req_addr[1:0]);
  // all strobes decode from the state register so reset kills them at once
  assign req_ready = state == IDLE;
  assign MemRead = state == RD || state == RMW_RD;
  assign MemWrite = state == WR;
  assign done = state == DONE || state == FAULT;
  assign fault = state == FAULT;
  assign mem_addr = addr[ADDR_WIDTH+1:2];
  assign mem_wdata = wbuf;
  // request sequencing: accept, read/merge/write, then a one-cycle completion state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sz <= '0;
      addr <= '0;
      wbuf <= '0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          sz <= req_size;
          addr <= req_addr[ADDR_WIDTH+1:0];
          wbuf <= req_wdata;
          state <= bad ? FAULT : !req_store ? RD : req_size == 3'b011 ? WR : RMW_RD;
        end
        RD: begin
          load_data <= ld;
          state <= DONE;
        end
        RMW_RD: begin
          wbuf <= merged;
          state <= WR;
        end
        WR: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: scoreboard bench with a negedge-write memory model
module tb_data_mem_access_unit;
  logic clk = 0, rst_n = 0, req_valid = 0, req_store = 0;
  logic [2:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, load_data, mem_wdata, mem_rdata;
  logic req_ready, done, fault, MemRead, MemWrite;
  logic [5:0] mem_addr;
  logic [31:0] mem [0:63] = '{default: '0};
  typedef struct {string tag; logic f; logic [31:0] ld; int lat; int acc; int nr; int nw; int r0; int w0;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, cyc = 0, nr = 0, nw = 0;
  logic [31:0] exp_ld = 0, lw_d = 0;
  logic [5:0] lw_a = 0;
  logic prev_done = 0;
  data_mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .fault(fault), .load_data(load_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (MemWrite) begin
      mem[mem_addr] = mem_wdata;
      nw++;
      lw_a = mem_addr;
      lw_d = mem_wdata;
    end
    if (MemRead) nr++;
    if (done) begin
      check("done_b2b", {31'b0, prev_done}, 0);
      if (q.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        check({e.tag, "_fault"}, {31'b0, fault}, {31'b0, e.f});
        check({e.tag, "_data"}, load_data, e.ld);
        check({e.tag, "_lat"}, cyc - e.acc + 1, e.lat);
        check({e.tag, "_reads"}, nr - e.r0, e.nr);
        check({e.tag, "_writes"}, nw - e.w0, e.nw);
      end
    end
    prev_done = done;
  end
  task automatic send(input string tag, input logic st, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic f, input logic [31:0] ld, input logic hold);
    exp_t x;
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    req_valid = 1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
    if (!f && !st) exp_ld = ld;
    x.tag = tag; x.f = f; x.ld = exp_ld; x.acc = cyc + 1; x.r0 = nr; x.w0 = nw;
    x.lat = f ? 1 : (!st || sz == 3'b011) ? 2 : 3;
    x.nr = (f || (st && sz == 3'b011)) ? 0 : 1;
    x.nw = (!f && st) ? 1 : 0;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_done", {30'b0, done, fault}, 0);
    check("rst_mem", {30'b0, MemRead, MemWrite}, 0);
    check("rst_ld", load_data, 0);
    check("rst_maddr", {26'b0, mem_addr}, 0);
    check("rst_wdata", mem_wdata, 0);
    rst_n = 1;
    send("sw10", 1, 3'b011, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    drain();
    check("sw10_mem4", mem[4], 32'hDEADBEEF);
    check("sw10_waddr", {26'b0, lw_a}, 4);
    send("lb11", 0, 3'b000, 32'h11, 0, 0, 32'hFFFFFFBE, 0);
    send("lbu11", 0, 3'b100, 32'h11, 0, 0, 32'h000000BE, 0);
    send("lh12", 0, 3'b001, 32'h12, 0, 0, 32'hFFFFDEAD, 0);
    send("lhu12", 0, 3'b101, 32'h12, 0, 0, 32'h0000DEAD, 0);
    send("lw10", 0, 3'b011, 32'h10, 0, 0, 32'hDEADBEEF, 0);
    send("sb13", 1, 3'b000, 32'h13, 32'h00000012, 0, 0, 0);
    drain();
    check("sb13_wdata", lw_d, 32'h12ADBEEF);
    send("sh10", 1, 3'b001, 32'h10, 32'h00005555, 0, 0, 0);
    send("lw10b", 0, 3'b011, 32'h10, 0, 0, 32'h12AD5555, 0);
    send("f_lw02", 0, 3'b011, 32'h02, 0, 1, 0, 0);
    send("f_lh01", 0, 3'b001, 32'h01, 0, 1, 0, 0);
    send("f_lb100", 0, 3'b000, 32'h100, 0, 1, 0, 0);
    send("f_sz2", 0, 3'b010, 32'h00, 0, 1, 0, 0);
    send("f_sw101", 1, 3'b011, 32'h101, 32'h1, 1, 0, 0);
    send("f_sh23", 1, 3'b001, 32'h23, 32'h1, 1, 0, 0);
    drain();
    check("f_mem4", mem[4], 32'h12AD5555);
    send("sb_rst", 1, 3'b000, 32'h20, 32'hAA, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 0;
    q.delete();
    #1;
    check("rst_mw_drop", {30'b0, MemRead, MemWrite}, 0);
    repeat (2) @(negedge clk);
    check("rst_mem8", mem[8], 0);
    check("rst_nodone", {31'b0, done}, 0);
    rst_n = 1;
    exp_ld = 0;
    @(negedge clk);
    check("rst_ready2", {31'b0, req_ready}, 1);
    check("rst_ld2", load_data, 0);
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      send("b2b_sw", 1, 3'b011, 32'h40 + 4 * i, d, 0, 0, 1);
      send("b2b_lw", 0, 3'b011, 32'h40 + 4 * i, 0, 0, d, 1);
    end
    req_valid = 0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
